alu_response_checker: RTL and testbench

- Synthesizable in-fabric response checker for alu_design.
- Sits on the receive side of the ALU: it takes each issued operation with its expected packet, aligns it to the operation's result latency, and compares against live DUT outputs.
- Keeps pass/fail/skip counters and captures the first failing feature tag.
- Lets FPGA/emulation runs self-check without a simulator-side scoreboard.

---
 rtl/alu_response_checker.sv | 162 ++++++++++++++++
 tb/tb_alu_response_checker.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_response_checker.sv
// Receive-side checker for alu_design. Each issued operation's expected packet is
// held in a delay line until its result latency, then compared against the live ALU outputs.
module alu_response_checker_slot #(
  parameter int W = 30
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_vld,
  input  logic [W-1:0] shift_data,
  output logic         vld,
  output logic [W-1:0] data
);
  // A fresh issue wins over the entry shifting in; the top counts the loser as a skip.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (clr) begin
      vld  <= 1'b0;
    end else if (load) begin
      vld  <= 1'b1;
      data <= load_data;
    end else begin
      vld  <= shift_vld;
      data <= shift_data;
    end
  end
endmodule

module alu_response_checker #(
  parameter int                   OPERAND_WIDTH = 8,
  parameter int                   CMD_WIDTH     = 4,
  parameter int                   LAT_STD       = 1,
  parameter int                   LAT_MUL       = 2,
  parameter logic [CMD_WIDTH-1:0] MUL_CMD0      = 4'h9,
  parameter logic [CMD_WIDTH-1:0] MUL_CMD1      = 4'hA,
  parameter int                   CNT_WIDTH     = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CLR,
  input  logic                       ISS_VALID,
  input  logic                       ISS_CE,
  input  logic                       ISS_MODE,
  input  logic [CMD_WIDTH-1:0]       ISS_CMD,
  input  logic [7:0]                 ISS_TAG,
  input  logic [2*OPERAND_WIDTH-1:0] EXP_RES,
  input  logic [5:0]                 EXP_FLAGS,
  input  logic [2*OPERAND_WIDTH-1:0] DUT_RES,
  input  logic [5:0]                 DUT_FLAGS,
  output logic                       CHK_VALID,
  output logic                       CHK_PASS,
  output logic [7:0]                 CHK_TAG,
  output logic [CNT_WIDTH-1:0]       PASS_CNT,
  output logic [CNT_WIDTH-1:0]       FAIL_CNT,
  output logic [CNT_WIDTH-1:0]       SKIP_CNT,
  output logic                       FAIL_SEEN,
  output logic [7:0]                 FIRST_FAIL_TAG,
  output logic                       IDLE
);
  localparam int RES_W = 2*OPERAND_WIDTH;

  typedef struct packed {
    logic [7:0]       tag;
    logic [RES_W-1:0] res;
    logic [5:0]       flags;
  } entry_t;

  localparam int ENT_W = $bits(entry_t);

  logic   is_mul, iss_store, collide, cmp, match, skip_inc;
  entry_t iss_ent, cmp_ent;

  // slot k holds the entry due k+1 edges from now; slot 0 is compared at the next edge
  logic [LAT_MUL-1:0]            slot_vld, nxt_vld, slot_load, shift_vld;
  logic [LAT_MUL-1:0][ENT_W-1:0] slot_data, shift_data;

  assign is_mul    = ISS_MODE && ((ISS_CMD == MUL_CMD0) || (ISS_CMD == MUL_CMD1));
  assign iss_store = ISS_VALID && ISS_CE;
  assign iss_ent   = '{tag: ISS_TAG, res: EXP_RES, flags: EXP_FLAGS};

  // Only a short-latency issue can land on a slot already claimed by an older long op.
  assign collide   = iss_store && !is_mul && slot_vld[LAT_STD];
  assign skip_inc  = (ISS_VALID && !ISS_CE) || collide;

  assign cmp       = slot_vld[0];
  assign cmp_ent   = entry_t'(slot_data[0]);
  assign match     = (DUT_RES == cmp_ent.res) && (DUT_FLAGS == cmp_ent.flags);

  generate
    for (genvar k = 0; k < LAT_MUL; k++) begin : g_slot
      if (k == LAT_MUL-1) begin : g_tail
        assign shift_vld[k]  = 1'b0;
        assign shift_data[k] = '0;
      end else begin : g_body
        assign shift_vld[k]  = slot_vld[k+1];
        assign shift_data[k] = slot_data[k+1];
      end

      assign slot_load[k] = iss_store && (is_mul ? (k == LAT_MUL-1) : (k == LAT_STD-1));
      assign nxt_vld[k]   = slot_load[k] || shift_vld[k];

      alu_response_checker_slot #(.W(ENT_W)) u_slot (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clr        (CLR),
        .load       (slot_load[k]),
        .load_data  (iss_ent),
        .shift_vld  (shift_vld[k]),
        .shift_data (shift_data[k]),
        .vld        (slot_vld[k]),
        .data       (slot_data[k])
      );
    end
  endgenerate

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CHK_VALID      <= 1'b0;
      CHK_PASS       <= 1'b0;
      CHK_TAG        <= '0;
      PASS_CNT       <= '0;
      FAIL_CNT       <= '0;
      SKIP_CNT       <= '0;
      FAIL_SEEN      <= 1'b0;
      FIRST_FAIL_TAG <= '0;
      IDLE           <= 1'b1;
    end else if (CLR) begin
      CHK_VALID      <= 1'b0;
      PASS_CNT       <= '0;
      FAIL_CNT       <= '0;
      SKIP_CNT       <= '0;
      FAIL_SEEN      <= 1'b0;
      FIRST_FAIL_TAG <= '0;
      IDLE           <= 1'b1;
    end else begin
      CHK_VALID <= cmp;
      if (cmp) begin
        CHK_PASS <= match;
        CHK_TAG  <= cmp_ent.tag;
        if (match) begin
          PASS_CNT <= sat_inc(PASS_CNT);
        end else begin
          FAIL_CNT <= sat_inc(FAIL_CNT);
          if (!FAIL_SEEN) begin
            FAIL_SEEN      <= 1'b1;
            FIRST_FAIL_TAG <= cmp_ent.tag;
          end
        end
      end
      if (skip_inc) SKIP_CNT <= sat_inc(SKIP_CNT);
      IDLE <= ~|nxt_vld;
    end
  end
endmodule

// File: tb/tb_alu_response_checker.sv
// Bench for alu_response_checker: directed vector table, reset/saturation sequences,
// and random traffic checked against a target-cycle keyed reference model.
module tb_alu_response_checker;
  logic        clk = 1'b0;
  logic        rst_n, clr, iv, ce, mode;
  logic [3:0]  cmd;
  logic [7:0]  tag;
  logic [15:0] eres, dres;
  logic [5:0]  eflg, dflg;
  logic        chk_valid, chk_pass, fail_seen, idle;
  logic [7:0]  chk_tag, first_tag;
  logic [15:0] pass_cnt, fail_cnt, skip_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  alu_response_checker #(
    .OPERAND_WIDTH(8), .CMD_WIDTH(4), .LAT_STD(1), .LAT_MUL(2),
    .MUL_CMD0(4'h9), .MUL_CMD1(4'hA), .CNT_WIDTH(16)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .CLR(clr),
    .ISS_VALID(iv), .ISS_CE(ce), .ISS_MODE(mode), .ISS_CMD(cmd), .ISS_TAG(tag),
    .EXP_RES(eres), .EXP_FLAGS(eflg), .DUT_RES(dres), .DUT_FLAGS(dflg),
    .CHK_VALID(chk_valid), .CHK_PASS(chk_pass), .CHK_TAG(chk_tag),
    .PASS_CNT(pass_cnt), .FAIL_CNT(fail_cnt), .SKIP_CNT(skip_cnt),
    .FAIL_SEEN(fail_seen), .FIRST_FAIL_TAG(first_tag), .IDLE(idle)
  );

  typedef struct {
    logic        v, p;
    logic [7:0]  tg;
    logic [15:0] ps, fl, sk;
    logic        seen;
    logic [7:0]  first;
    logic        idl;
  } obs_t;

  typedef struct {
    logic        c, v, e, m;
    logic [3:0]  cd;
    logic [7:0]  tg;
    logic [15:0] er;
    logic [5:0]  ef;
    logic [15:0] dr;
    logic [5:0]  df;
    obs_t        x;
  } row_t;

  // reference model: pending entries keyed by the absolute cycle they are due
  typedef struct {
    logic [7:0]  tg;
    logic [15:0] res;
    logic [5:0]  flg;
  } ent_t;

  ent_t       pend[int];
  int         cyc = 0;
  logic       m_v, m_p, m_seen;
  logic [7:0] m_tag, m_first;
  int         m_pass, m_fail, m_skip;

  function automatic logic [15:0] sat16(input int c);
    return (c > 65535) ? 16'hFFFF : c[15:0];
  endfunction

  task automatic model_reset();
    pend.delete();
    m_v = 0; m_p = 0; m_tag = 0; m_seen = 0; m_first = 0;
    m_pass = 0; m_fail = 0; m_skip = 0;
  endtask

  task automatic model_edge();
    int lt;
    m_v = 0;
    if (clr) begin
      pend.delete();
      m_pass = 0; m_fail = 0; m_skip = 0; m_seen = 0; m_first = 0;
    end else begin
      if (pend.exists(cyc)) begin
        ent_t e;
        e = pend[cyc];
        pend.delete(cyc);
        m_v = 1;
        m_p = (e.res == dres) && (e.flg == dflg);
        m_tag = e.tg;
        if (m_p) m_pass++;
        else begin
          m_fail++;
          if (!m_seen) begin m_seen = 1; m_first = e.tg; end
        end
      end
      if (iv) begin
        if (!ce) m_skip++;
        else begin
          lt = (mode && (cmd == 4'h9 || cmd == 4'hA)) ? 2 : 1;
          if (pend.exists(cyc + lt)) m_skip++;
          pend[cyc + lt] = '{tg: tag, res: eres, flg: eflg};
        end
      end
    end
    cyc++;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o = '{v: m_v, p: m_p, tg: m_tag, ps: sat16(m_pass), fl: sat16(m_fail), sk: sat16(m_skip),
          seen: m_seen, first: m_first, idl: (pend.num() == 0)};
    return o;
  endfunction

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_cmp++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  task automatic check_obs(input string ctx, input obs_t x);
    chk({ctx, ".chk_valid"}, 16'(chk_valid), 16'(x.v));
    chk({ctx, ".chk_pass"},  16'(chk_pass),  16'(x.p));
    chk({ctx, ".chk_tag"},   16'(chk_tag),   16'(x.tg));
    chk({ctx, ".pass_cnt"},  pass_cnt,       x.ps);
    chk({ctx, ".fail_cnt"},  fail_cnt,       x.fl);
    chk({ctx, ".skip_cnt"},  skip_cnt,       x.sk);
    chk({ctx, ".fail_seen"}, 16'(fail_seen), 16'(x.seen));
    chk({ctx, ".first_tag"}, 16'(first_tag), 16'(x.first));
    chk({ctx, ".idle"},      16'(idle),      16'(x.idl));
  endtask

  task automatic set_idle();
    clr = 0; iv = 0; ce = 0; mode = 0; cmd = 0; tag = 0; eres = 0; eflg = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t mk(input int c, v, e, m, cd, tg, er, ef, dr, df,
                              input int xv, xp, xt, xps, xfl, xsk, xs, xf, xi);
    row_t r;
    r.c = c[0]; r.v = v[0]; r.e = e[0]; r.m = m[0]; r.cd = cd[3:0]; r.tg = tg[7:0];
    r.er = er[15:0]; r.ef = ef[5:0]; r.dr = dr[15:0]; r.df = df[5:0];
    r.x = '{v: xv[0], p: xp[0], tg: xt[7:0], ps: xps[15:0], fl: xfl[15:0], sk: xsk[15:0],
            seen: xs[0], first: xf[7:0], idl: xi[0]};
    return r;
  endfunction

  row_t tbl[$];
  obs_t rst_obs;

  initial begin
    #5_000_000;
    n_mis++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    // clr iv ce md cmd tag  eres  eflg dres  dflg | v p tag pass fail skip seen first idle
    tbl.push_back(mk(0,1,1,0,0,'h01,'h0010,0,'h0000,0,  0,0,'h00,0,0,0,0,'h00,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0010,0,          1,1,'h01,1,0,0,0,'h00,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0000,0,          0,1,'h01,1,0,0,0,'h00,1));
    tbl.push_back(mk(0,1,1,1,9,'h05,'h00F0,0,'h0000,0,  0,1,'h01,1,0,0,0,'h00,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0000,0,          0,1,'h01,1,0,0,0,'h00,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h00F0,0,          1,1,'h05,2,0,0,0,'h00,1));
    tbl.push_back(mk(0,1,1,0,0,'h07,'h0000,1,'h0000,0,  0,1,'h05,2,0,0,0,'h00,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0000,0,          1,0,'h07,2,1,0,1,'h07,1));
    tbl.push_back(mk(0,1,1,0,0,'h09,'h0001,0,'h0000,0,  0,0,'h07,2,1,0,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0000,0,          1,0,'h09,2,2,0,1,'h07,1));
    tbl.push_back(mk(0,1,1,1,9,'h0A,'h00AA,0,'h0000,0,  0,0,'h09,2,2,0,1,'h07,0));
    tbl.push_back(mk(0,1,1,0,0,'h0B,'h00BB,0,'h0000,0,  0,0,'h09,2,2,1,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h00BB,0,          1,1,'h0B,3,2,1,1,'h07,1));
    tbl.push_back(mk(0,1,1,1,10,'h0C,'h00CC,0,'h0000,0, 0,1,'h0B,3,2,1,1,'h07,0));
    tbl.push_back(mk(0,1,1,1,9,'h0D,'h00DD,0,'h0000,0,  0,1,'h0B,3,2,1,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h00CC,0,          1,1,'h0C,4,2,1,1,'h07,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h00DD,0,          1,1,'h0D,5,2,1,1,'h07,1));
    tbl.push_back(mk(0,1,0,0,0,'h0E,'h0000,0,'h0000,0,  0,1,'h0D,5,2,2,1,'h07,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0000,0,          0,1,'h0D,5,2,2,1,'h07,1));
    tbl.push_back(mk(1,1,1,0,0,'h0F,'h00FF,0,'h00FF,0,  0,1,'h0D,0,0,0,0,'h00,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h00FF,0,          0,1,'h0D,0,0,0,0,'h00,1));
    // MODE=0 with a multiply command code is a standard-latency op
    tbl.push_back(mk(0,1,1,0,9,'h10,'h0100,0,'h0000,0,  0,1,'h0D,0,0,0,0,'h00,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,'h0100,0,          1,1,'h10,1,0,0,0,'h00,1));

    rst_obs = '{v: 0, p: 0, tg: 0, ps: 0, fl: 0, sk: 0, seen: 0, first: 0, idl: 1};

    rst_n = 0; set_idle(); dres = 0; dflg = 0;
    #12;
    check_obs("reset", rst_obs);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tbl.size(); i++) begin
      clr = tbl[i].c; iv = tbl[i].v; ce = tbl[i].e; mode = tbl[i].m; cmd = tbl[i].cd;
      tag = tbl[i].tg; eres = tbl[i].er; eflg = tbl[i].ef; dres = tbl[i].dr; dflg = tbl[i].df;
      step();
      check_obs($sformatf("row%0d", i), tbl[i].x);
    end

    // reset one cycle after a multiply issue discards it
    set_idle(); iv = 1; ce = 1; mode = 1; cmd = 4'h9; tag = 8'h21; eres = 16'h00F0; dres = 0;
    step();
    set_idle();
    rst_n = 0;
    #1;
    check_obs("midrst", rst_obs);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    dres = 16'h00F0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_obs($sformatf("postrst%0d", i), rst_obs);
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      clr  = ($urandom_range(0, 99) < 2);
      iv   = ($urandom_range(0, 9) < 6);
      ce   = ($urandom_range(0, 9) < 8);
      mode = $urandom_range(0, 1) == 1;
      r    = $urandom_range(0, 3);
      cmd  = (r == 0) ? 4'h9 : (r == 1) ? 4'hA : 4'($urandom);
      tag  = 8'($urandom);
      eres = 16'($urandom);
      eflg = 6'($urandom);
      if (pend.exists(cyc) && $urandom_range(0, 3) != 0) begin
        dres = pend[cyc].res;
        dflg = pend[cyc].flg;
        if ($urandom_range(0, 7) == 0) dflg[$urandom_range(0, 5)] ^= 1'b1;
      end else begin
        dres = 16'($urandom);
        dflg = 6'($urandom);
      end
      step();
      check_obs($sformatf("rand%0d", i), model_obs());
    end

    // pass counter saturation
    set_idle(); clr = 1;
    step();
    check_obs("preclr", model_obs());
    set_idle(); iv = 1; ce = 1; tag = 8'h55; eres = 16'h1234; dres = 16'h1234; dflg = 0;
    for (int i = 0; i < 65540; i++) begin
      step();
      if (i == 65534) chk("sat.pass_fffe", pass_cnt, 16'hFFFE);
      if (i == 65535) chk("sat.pass_ffff", pass_cnt, 16'hFFFF);
    end
    chk("sat.pass_hold", pass_cnt, 16'hFFFF);
    check_obs("sat", model_obs());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
